// File: rtl/motor_speed_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : motor_pkg
//  Description : Shared widths, limits, state encoding and the rate clamp
//                helper for the motor speed sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam int RATE_W   = 7;
    localparam int MAX_RATE = 99;

    // Explicit 3-bit encoding so the state register width is fixed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        BRAKE = 3'd2,
        DWELL = 3'd3,
        ESTOP = 3'd4
    } state_t;

    // Saturate a requested rate at the configured ceiling.
    function automatic logic [RATE_W-1:0] clamp_rate(
        input logic [RATE_W-1:0] req,
        input logic [RATE_W-1:0] lim
    );
        return (req > lim) ? lim : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_speed_sequencer_ramp_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ramp_tick_gen
//  Description : Free-running prescaler producing one tick every RAMP_DIV
//                clocks. A restart zeroes the count and suppresses any tick
//                falling in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramp_tick_gen #(
    parameter int RAMP_DIV = 1000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              CNT_W  = $clog2(RAMP_DIV);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count 0..RAMP_DIV-1, wrapping on the last value or on restart.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_restart;

endmodule
`default_nettype wire

// File: rtl/motor_speed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : motor_speed_sequencer
//  Description : Turns decoded remote commands into a soft-ramped PWM duty
//                setting, forcing ramp-to-zero plus a dead time before any
//                direction reversal, with an emergency-stop override.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_speed_sequencer #(
    parameter int RAMP_DIV  = 1000,
    parameter int DEAD_TIME = 5000,
    parameter int MAX_RATE  = motor_pkg::MAX_RATE
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        CmdValid,
    input  logic [motor_pkg::RATE_W-1:0] CmdSpeed,
    input  logic                        CmdDir,
    input  logic                        EStop,
    output logic [motor_pkg::RATE_W-1:0] RateSet,
    output logic                        Dir,
    output logic                        AtSpeed,
    output logic                        Busy
);

    import motor_pkg::*;

    localparam int                 DWELL_W      = $clog2(DEAD_TIME + 1);
    localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DEAD_TIME - 1);
    localparam logic [RATE_W-1:0]  c_max_rate   = RATE_W'(MAX_RATE);

    state_t              r_state,    w_state_nxt;
    logic [RATE_W-1:0]   r_rate,     w_rate_nxt;
    logic                r_dir,      w_dir_nxt;
    logic [RATE_W-1:0]   r_target,   w_target_nxt;
    logic                r_tgt_dir,  w_tgt_dir_nxt;
    logic [DWELL_W-1:0]  r_dwell,    w_dwell_nxt;
    logic                r_at_speed, w_at_speed_nxt;
    logic                r_busy,     w_busy_nxt;

    logic                w_accept;
    logic                w_tick;
    logic [RATE_W-1:0]   w_cmd_rate;

    // Commands are dropped while stopping or while latched in emergency stop.
    assign w_accept   = CmdValid && !EStop && (r_state != ESTOP);
    assign w_cmd_rate = clamp_rate(CmdSpeed, c_max_rate);

    // Each accepted command re-phases the ramp so its first step is a full period away.
    ramp_tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp_tick_gen (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    // State, rate and direction registers; status flags track the next values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= IDLE;
            r_rate     <= '0;
            r_dir      <= 1'b0;
            r_target   <= '0;
            r_tgt_dir  <= 1'b0;
            r_dwell    <= '0;
            r_at_speed <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate     <= w_rate_nxt;
            r_dir      <= w_dir_nxt;
            r_target   <= w_target_nxt;
            r_tgt_dir  <= w_tgt_dir_nxt;
            r_dwell    <= w_dwell_nxt;
            r_at_speed <= w_at_speed_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state logic: EStop first, then accepted commands, then ramp ticks.
    always_comb begin
        w_state_nxt   = r_state;
        w_rate_nxt    = r_rate;
        w_dir_nxt     = r_dir;
        w_target_nxt  = r_target;
        w_tgt_dir_nxt = r_tgt_dir;
        w_dwell_nxt   = r_dwell;

        if (w_accept) begin
            w_target_nxt  = w_cmd_rate;
            w_tgt_dir_nxt = CmdDir;
        end

        if (EStop) begin
            w_state_nxt  = ESTOP;
            w_rate_nxt   = '0;
            w_target_nxt = '0;
            w_dwell_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Motor is stationary, so direction can be taken immediately.
                    if (w_accept && (w_cmd_rate != '0)) begin
                        w_state_nxt = RUN;
                        w_dir_nxt   = CmdDir;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (CmdDir != r_dir) begin
                            w_state_nxt = (r_rate == '0) ? DWELL : BRAKE;
                            w_dwell_nxt = '0;
                        end
                    end else if ((r_rate == '0) && (r_target == '0)) begin
                        w_state_nxt = IDLE;
                    end else if (w_tick) begin
                        if (r_rate < r_target) begin
                            w_rate_nxt = r_rate + RATE_W'(1);
                        end else if (r_rate > r_target) begin
                            w_rate_nxt = r_rate - RATE_W'(1);
                        end
                    end
                end
                BRAKE: begin
                    if (w_accept) begin
                        // Reversal cancelled: keep the current rate and ramp on from it.
                        if (CmdDir == r_dir) begin
                            w_state_nxt = RUN;
                        end
                    end else if (r_rate == '0) begin
                        w_state_nxt = DWELL;
                        w_dwell_nxt = '0;
                    end else if (w_tick) begin
                        w_rate_nxt = r_rate - RATE_W'(1);
                        if (r_rate == RATE_W'(1)) begin
                            w_state_nxt = DWELL;
                            w_dwell_nxt = '0;
                        end
                    end
                end
                DWELL: begin
                    w_rate_nxt = '0;
                    if (r_dwell == c_dwell_last) begin
                        w_dwell_nxt = '0;
                        w_dir_nxt   = w_tgt_dir_nxt;
                        w_state_nxt = (w_target_nxt != '0) ? RUN : IDLE;
                    end else begin
                        w_dwell_nxt = r_dwell + DWELL_W'(1);
                    end
                end
                ESTOP: begin
                    // EStop has dropped: always serve a full dead time before idling.
                    w_state_nxt = DWELL;
                    w_dwell_nxt = '0;
                    w_rate_nxt  = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rate_nxt  = '0;
                end
            endcase
        end
    end

    // Status flags evaluated on the values about to be registered.
    always_comb begin
        w_at_speed_nxt = (w_state_nxt == RUN) && (w_rate_nxt == w_target_nxt) &&
                         (w_target_nxt != '0);
        w_busy_nxt     = (w_state_nxt == BRAKE) || (w_state_nxt == DWELL) ||
                         (w_state_nxt == ESTOP) ||
                         ((w_state_nxt == RUN) && (w_rate_nxt != w_target_nxt));
    end

    assign RateSet = r_rate;
    assign Dir     = r_dir;
    assign AtSpeed = r_at_speed;
    assign Busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_motor_speed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_speed_sequencer
//  Description : Scoreboard bench for motor_speed_sequencer with RAMP_DIV=4,
//                DEAD_TIME=8. Expected output values are queued against the
//                clock edge at which they must be visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_speed_sequencer;

    localparam int RAMP_DIV  = 4;
    localparam int DEAD_TIME = 8;

    localparam int F_RATE = 0;
    localparam int F_DIR  = 1;
    localparam int F_ATS  = 2;
    localparam int F_BUSY = 3;

    logic       Clk;
    logic       Rst;
    logic       CmdValid;
    logic [6:0] CmdSpeed;
    logic       CmdDir;
    logic       EStop;
    logic [6:0] RateSet;
    logic       Dir;
    logic       AtSpeed;
    logic       Busy;

    int n_cmp    = 0;
    int n_err    = 0;
    int edge_cnt = 0;

    typedef struct {
        int    edge_no;
        int    field;
        int    value;
        string tag;
    } exp_t;

    exp_t sb[$];

    motor_speed_sequencer #(
        .RAMP_DIV  (RAMP_DIV),
        .DEAD_TIME (DEAD_TIME),
        .MAX_RATE  (99)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .CmdValid (CmdValid),
        .CmdSpeed (CmdSpeed),
        .CmdDir   (CmdDir),
        .EStop    (EStop),
        .RateSet  (RateSet),
        .Dir      (Dir),
        .AtSpeed  (AtSpeed),
        .Busy     (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic int observe(input int f);
        case (f)
            F_RATE:  return int'(RateSet);
            F_DIR:   return int'(Dir);
            F_ATS:   return int'(AtSpeed);
            default: return int'(Busy);
        endcase
    endfunction

    task automatic exp_at(input int e, input int f, input int v, input string tag);
        exp_t x;
        x.edge_no = e;
        x.field   = f;
        x.value   = v;
        x.tag     = tag;
        sb.push_back(x);
    endtask

    task automatic exp_all(input int e, input int rate, input int dir,
                           input int ats, input int busy, input string tag);
        exp_at(e, F_RATE, rate, $sformatf("%s.rate", tag));
        exp_at(e, F_DIR,  dir,  $sformatf("%s.dir", tag));
        exp_at(e, F_ATS,  ats,  $sformatf("%s.atspeed", tag));
        exp_at(e, F_BUSY, busy, $sformatf("%s.busy", tag));
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) @(negedge Clk);
    endtask

    // Drives a one-cycle command; returns the edge at which it is accepted.
    task automatic send_cmd(input int spd, input bit dir, output int acc);
        @(negedge Clk);
        CmdValid = 1'b1;
        CmdSpeed = 7'(spd);
        CmdDir   = dir;
        acc      = edge_cnt + 1;
        @(negedge Clk);
        CmdValid = 1'b0;
    endtask

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    // Compare every queued expectation that has come due at this edge.
    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].edge_no <= edge_cnt) begin
                check_value(sb[i].tag, observe(sb[i].field), sb[i].value);
                sb.delete(i);
            end
        end
    end

    initial begin
        int a;
        int b;
        int e;
        int r;

        Rst      = 1'b0;
        CmdValid = 1'b0;
        CmdSpeed = '0;
        CmdDir   = 1'b0;
        EStop    = 1'b0;

        // Reset state, then a long quiet stretch with no commands.
        repeat (3) @(negedge Clk);
        check_value("rst.rate",    int'(RateSet), 0);
        check_value("rst.dir",     int'(Dir),     0);
        check_value("rst.atspeed", int'(AtSpeed), 0);
        check_value("rst.busy",    int'(Busy),    0);
        Rst = 1'b1;
        r   = edge_cnt;
        exp_all(r + 1,   0, 0, 0, 0, "idle1");
        exp_all(r + 50,  0, 0, 0, 0, "idle50");
        exp_all(r + 100, 0, 0, 0, 0, "idle100");
        wait_until(r + 100);

        // Soft start to 5: one step every 4 clocks, first one 4 clocks after accept.
        send_cmd(5, 1'b0, a);
        exp_all(a, 0, 0, 0, 1, "acc5");
        exp_at(a + 3, F_RATE, 0, "ramp_early");
        for (int k = 1; k <= 5; k++) exp_at(a + 4 * k, F_RATE, k, "ramp_up");
        exp_at(a + 19, F_ATS,  0, "pre5.atspeed");
        exp_at(a + 19, F_BUSY, 1, "pre5.busy");
        exp_all(a + 20, 5, 0, 1, 0, "at5");
        exp_at(a + 24, F_RATE, 5, "hold5");
        wait_until(a + 24);

        // Reversal: brake 5->0, 8-clock dwell, then Dir flips and ramp to 3.
        send_cmd(3, 1'b1, a);
        for (int k = 1; k <= 5; k++) exp_at(a + 4 * k, F_RATE, 5 - k, "brake");
        exp_at(a + 20, F_DIR,  0, "brake_dir");
        exp_at(a + 24, F_BUSY, 1, "dwell_busy");
        exp_at(a + 27, F_RATE, 0, "dwell_rate");
        exp_at(a + 27, F_DIR,  0, "dwell_dir");
        exp_at(a + 28, F_DIR,  1, "rev_dir");
        exp_at(a + 31, F_RATE, 0, "rev_early");
        exp_at(a + 32, F_RATE, 1, "rev_up");
        exp_at(a + 36, F_RATE, 2, "rev_up");
        exp_at(a + 39, F_ATS,  0, "pre3.atspeed");
        exp_all(a + 40, 3, 1, 1, 0, "rev3");
        wait_until(a + 40);

        // Mid-brake cancel: going back to the original direction resumes from 3.
        send_cmd(3, 1'b0, a);
        exp_at(a + 1, F_BUSY, 1, "brk.busy");
        exp_at(a + 1, F_RATE, 3, "brk.rate");
        exp_at(a + 1, F_ATS,  0, "brk.atspeed");
        send_cmd(5, 1'b1, b);
        exp_at(b,     F_DIR,  1, "resume_dir");
        exp_at(b + 3, F_RATE, 3, "resume_hold");
        exp_at(b + 4, F_RATE, 4, "resume_up");
        exp_at(b + 4, F_DIR,  1, "resume_dir4");
        exp_all(b + 8, 5, 1, 1, 0, "resume5");
        exp_at(b + 10, F_RATE, 5, "pre_estop");
        wait_until(b + 10);

        // Emergency stop with a competing command that must be ignored.
        EStop    = 1'b1;
        CmdValid = 1'b1;
        CmdSpeed = 7'd50;
        CmdDir   = 1'b0;
        e        = edge_cnt + 1;
        exp_all(e, 0, 1, 0, 1, "estop");
        exp_at(e + 3, F_RATE, 0, "estop_hold");
        @(negedge Clk);
        CmdValid = 1'b0;
        repeat (4) @(negedge Clk);
        EStop = 1'b0;
        r     = edge_cnt + 1;
        exp_at(r + 7, F_BUSY, 1, "es_dwell.busy");
        exp_at(r + 7, F_RATE, 0, "es_dwell.rate");
        exp_all(r + 8,  0, 1, 0, 0, "es_idle");
        exp_all(r + 20, 0, 1, 0, 0, "es_quiet");
        wait_until(r + 20);

        // From idle: new command works, Dir taken at once, target clamps at 99.
        send_cmd(120, 1'b0, a);
        exp_all(a, 0, 0, 0, 1, "clamp_acc");
        exp_at(a + 4,   F_RATE, 1,  "clamp_first");
        exp_at(a + 200, F_RATE, 50, "clamp_mid");
        exp_at(a + 392, F_RATE, 98, "clamp_98");
        exp_all(a + 396, 99, 0, 1, 0, "clamp99");
        exp_at(a + 420, F_RATE, 99, "clamp_hold");
        wait_until(a + 420);

        // Asynchronous reset in the middle of a ramp down.
        send_cmd(50, 1'b0, a);
        exp_at(a + 4, F_RATE, 98, "down98");
        exp_at(a + 5, F_BUSY, 1,  "down_busy");
        wait_until(a + 6);
        Rst = 1'b0;
        #1;
        check_value("arst.rate",    int'(RateSet), 0);
        check_value("arst.dir",     int'(Dir),     0);
        check_value("arst.atspeed", int'(AtSpeed), 0);
        check_value("arst.busy",    int'(Busy),    0);
        @(negedge Clk);
        Rst = 1'b1;
        r   = edge_cnt;
        exp_all(r + 10, 0, 0, 0, 0, "post_rst");
        wait_until(r + 10);

        repeat (3) @(negedge Clk);
        check_value("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_speed_sequencer.md
Name: motor_speed_sequencer

Overview:
Sequences the duty-cycle setting of the motor PWM generator from decoded remote commands. It soft-starts and soft-stops by ramping the 0..99 rate one step per prescaled tick. It enforces ramp-to-zero plus a dead time before any direction reversal, and it provides an emergency-stop override. It sits between the remote command decoder and the PWM block; its RateSet output drives the PWM RateSet input directly.

Parameters:
RAMP_DIV, 1000, Clk cycles per ramp step (must be >= 2)
DEAD_TIME, 5000, Clk cycles the rate is held at 0 before a direction change takes effect (must be >= 1)
MAX_RATE, 99, saturation limit for the commanded rate

Ports:
Clk  in  1  system clock; all logic is on the rising edge
Rst  in  1  reset, asynchronous, active-low
CmdValid  in  1  single-cycle strobe; the command is accepted on this cycle
CmdSpeed  in  7  requested rate, 0..127; clamped to MAX_RATE
CmdDir  in  1  requested direction
EStop  in  1  level-sensitive emergency stop
RateSet  out  7  registered duty setting fed to the PWM
Dir  out  1  registered motor direction
AtSpeed  out  1  high in RUN when RateSet equals target
Busy  out  1  high when ramping, braking or dwelling

Behaviour:
- Reset (Rst low, async): RateSet=0, Dir=0, AtSpeed=0, Busy=0, target=0, tgt_dir=0, counters=0, state=IDLE. Reset asserted mid-operation zeroes every output immediately.
- Command accept: CmdValid high and not in ESTOP and EStop low:
  - target <= min(CmdSpeed, MAX_RATE); tgt_dir <= CmdDir.
  - Prescaler restarts at 0, and any tick in the same cycle is discarded.
  - The first step occurs exactly RAMP_DIV cycles after accept. A new command overrides the previous one at any time.
- Tick: the prescaler counts 0..RAMP_DIV-1 and pulses on RAMP_DIV-1. Each tick changes RateSet by at most 1. RateSet never leaves 0..MAX_RATE.
- State IDLE (RateSet=0):
  - Accept with target>0 → RUN. Dir <= tgt_dir in the same cycle, with no dwell.
- State RUN:
  - On tick: RateSet +1 if below target, -1 if above.
  - Accept with tgt_dir != Dir → BRAKE, or DWELL if RateSet==0.
  - RateSet==0 and target==0 → IDLE.
- State BRAKE:
  - On tick: RateSet -1. When RateSet reaches 0 → DWELL.
  - Accept with tgt_dir==Dir → RUN, resuming the ramp from the current RateSet.
- State DWELL:
  - RateSet=0; count DEAD_TIME cycles. Accepts in DWELL update target and tgt_dir only.
  - On expiry: Dir <= tgt_dir, then → RUN if target>0, else → IDLE.
- State ESTOP:
  - Entered from any state when EStop is high. RateSet=0 on the next clock edge (1-cycle latency); target cleared to 0.
  - CmdValid is ignored while EStop is high. Dir is unchanged.
  - On EStop low → DWELL (full DEAD_TIME), then IDLE.
- Priority: Rst > EStop > CmdValid > tick.
- AtSpeed = (state==RUN) && (RateSet==target) && (target>0). Registered, so it updates with RateSet.
- Busy = BRAKE or DWELL or ESTOP, or RUN with RateSet != target. IDLE gives Busy=0.
- Counter widths: prescaler $clog2(RAMP_DIV); dwell counter $clog2(DEAD_TIME+1).

Decomposition:
- Package motor_pkg: RATE_W=7, MAX_RATE=99, state enum {IDLE, RUN, BRAKE, DWELL, ESTOP}.
- Sub-module ramp_tick_gen: prescaler with a synchronous restart input and a tick output.
- The FSM, target registers and dwell counter live in the top module.

Test Plan (RAMP_DIV=4, DEAD_TIME=8):
- Release reset → RateSet=0, Dir=0, AtSpeed=0, Busy=0; no change for 100 cycles without a command.
- Cmd speed=5, dir=0 → RateSet steps 1,2,3,4,5 at accept+4, +8, +12, +16, +20; AtSpeed rises and Busy falls with the last step.
- Cmd speed=120 → target clamps to 99; the ramp stops at 99 after 396 cycles and never reaches 100.
- At rate 5 dir 0, cmd speed=3 dir=1 → ramp to 0 in 20 cycles, Dir stays 0, 8-cycle dwell with RateSet=0, then Dir=1 and the ramp reaches 3 after 12 more cycles.
- EStop high at rate 3 → RateSet=0 on the next edge; CmdValid during EStop is ignored. On release: 8-cycle dwell, then IDLE with Busy=0; a new command then works.
- Mid-BRAKE (rate 3), cmd back to the original dir → RUN resumes from 3 with no dwell. Rst pulse mid-ramp → all outputs 0 asynchronously.
